// File: rtl/chirp_sequencer.sv
// chirp_sequencer: initiator side of the chirp DDS control handshake.
// Holds a shadow copy of the 128-bit chirp parameter word. It arms the DDS,
// issues a one-cycle init, follows the DDS ready/active/done status, and
// separates chirps with a programmable gap until the burst count is reached,
// abort_in is seen, or the DDS stalls.
// Optional build macro: CHIRP_SEQ_TIMESTAMP_EN. When it is defined, a 64-bit
// free-running cycle count is captured on every init. When it is not defined,
// chirp_timestamp_out is tied to 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no burst in progress, waiting for start_in
// ARM       | DDS enabled, waiting for chirp_ready_in
// INIT      | one-cycle init pulse, active parameters just loaded
// WAIT_ACT  | waiting for the DDS to report chirp_active_in
// ACTIVE    | DDS sweeping, waiting for chirp_done_in
// GAP       | inter-chirp gap down-count
// DONE      | one-cycle burst end, DDS disabled

module chirp_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_MIN        = 2
) (
    input  logic          fmc_tclk,
    input  logic          fmc_tresetn,
    input  logic [127:0]  chirp_parameters_in,
    input  logic          param_valid_in,
    input  logic          start_in,
    input  logic          abort_in,
    input  logic          chirp_ready_in,
    input  logic          chirp_active_in,
    input  logic          chirp_done_in,
    output logic          chirp_init_out,
    output logic          chirp_enable_out,
    output logic [31:0]   freq_offset_out,
    output logic [31:0]   tuning_word_coeff_out,
    output logic [31:0]   chirp_count_max_out,
    output logic          busy_out,
    output logic          burst_done_out,
    output logic [15:0]   chirp_index_out,
    output logic          timeout_err_out,
    output logic [63:0]   chirp_timestamp_out
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_INIT,
        S_WAIT_ACT,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [127:0]       shadow;
    logic [127:0]       load_word;
    logic [15:0]        act_gap;
    logic [15:0]        act_num;
    logic [15:0]        gap_cnt;
    logic [15:0]        gap_load;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_counting;
    logic               tmo_hit;
    logic               tmo_fire;
    logic               burst_end;
    logic               load_active;
    logic               chirp_complete;
    logic               burst_start;

    // The timeout counter only advances while the sequencer waits on the DDS.
    assign tmo_counting = (state == S_ARM) || (state == S_WAIT_ACT) || (state == S_ACTIVE);
    assign tmo_hit      = tmo_counting && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // At the end of the gap, leave the burst on abort, or once a finite count
    // is reached.
    assign burst_end = abort_in || ((act_num != 16'd0) && (chirp_index_out == act_num));

    // GAP lasts gap_load+1 cycles, so a programmed gap of g gives g gap cycles.
    assign gap_load = (act_gap < 16'(GAP_MIN)) ? 16'(GAP_MIN - 1) : (act_gap - 16'd1);

    // A parameter word arriving in the same cycle as the active load bypasses
    // the shadow register.
    assign load_word = param_valid_in ? chirp_parameters_in : shadow;

    assign load_active    = (state == S_ARM) && (state_nxt == S_INIT);
    assign chirp_complete = ((state == S_WAIT_ACT) || (state == S_ACTIVE)) && (state_nxt == S_GAP);
    assign burst_start    = (state == S_IDLE) && start_in;

    // Next-state selection. Progress from the DDS takes priority over the
    // timeout, and abort in ARM takes priority over everything.
    always_comb begin
        state_nxt = state;
        tmo_fire  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_in) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (abort_in) begin
                    state_nxt = S_DONE;
                end else if (chirp_ready_in) begin
                    state_nxt = S_INIT;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                    tmo_fire  = 1'b1;
                end
            end
            S_INIT: begin
                state_nxt = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (chirp_active_in) begin
                    state_nxt = S_ACTIVE;
                end else if (chirp_done_in) begin
                    state_nxt = S_GAP;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                    tmo_fire  = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (chirp_done_in) begin
                    state_nxt = S_GAP;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                    tmo_fire  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == 16'd0) state_nxt = burst_end ? S_DONE : S_ARM;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Status outputs decode directly from the state, so they clear as soon as reset is asserted.
    assign chirp_init_out   = (state == S_INIT);
    assign chirp_enable_out = (state == S_ARM) || (state == S_INIT) || (state == S_WAIT_ACT) ||
                              (state == S_ACTIVE) || (state == S_GAP);
    assign busy_out         = (state != S_IDLE);
    assign burst_done_out   = (state == S_DONE);

    // Shadow register, written whenever a new parameter word is offered.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn)        shadow <= '0;
        else if (param_valid_in) shadow <= chirp_parameters_in;
    end

    // Active parameters are taken from the shadow (or bypass word) on entry to INIT.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn) begin
            freq_offset_out       <= '0;
            tuning_word_coeff_out <= '0;
            chirp_count_max_out   <= '0;
            act_num               <= '0;
            act_gap               <= '0;
        end else if (load_active) begin
            freq_offset_out       <= load_word[31:0];
            tuning_word_coeff_out <= load_word[63:32];
            chirp_count_max_out   <= load_word[95:64];
            act_num               <= load_word[111:96];
            act_gap               <= load_word[127:112];
        end
    end

    // Inter-chirp gap down-counter, loaded when GAP is entered.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn) begin
            gap_cnt <= '0;
        end else if (chirp_complete) begin
            gap_cnt <= gap_load;
        end else if ((state == S_GAP) && (gap_cnt != 16'd0)) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

    // Timeout counter: cleared on every state change, advances only while waiting on the DDS.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (tmo_counting && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Completed-chirp count for the current burst; wraps naturally at 16 bits.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn)        chirp_index_out <= '0;
        else if (burst_start)    chirp_index_out <= '0;
        else if (chirp_complete) chirp_index_out <= chirp_index_out + 16'd1;
    end

    // Sticky timeout flag, cleared only when a new burst is accepted.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn)     timeout_err_out <= 1'b0;
        else if (burst_start) timeout_err_out <= 1'b0;
        else if (tmo_fire)    timeout_err_out <= 1'b1;
    end

`ifdef CHIRP_SEQ_TIMESTAMP_EN
    logic [63:0] ts_cnt;

    // Free-running cycle counter.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn) ts_cnt <= '0;
        else              ts_cnt <= ts_cnt + 64'd1;
    end

    // Capture the counter during the init cycle and hold it until the next init.
    always_ff @(posedge fmc_tclk or negedge fmc_tresetn) begin
        if (!fmc_tresetn)          chirp_timestamp_out <= '0;
        else if (state == S_INIT)  chirp_timestamp_out <= ts_cnt;
    end
`else
    assign chirp_timestamp_out = 64'd0;
`endif

endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench for chirp_sequencer. The timeline model predicts each burst
// from its shape: inits occur every 23+max(gap,2) cycles, and burst end falls
// 22+gap cycles after the last init. A DDS stand-in raises active one cycle
// after init and pulses done 20 cycles later.
module tb_chirp_sequencer;

    logic         fmc_tclk = 1'b0;
    logic         fmc_tresetn;
    logic [127:0] chirp_parameters_in;
    logic         param_valid_in;
    logic         start_in;
    logic         abort_in;
    logic         chirp_ready_in;
    logic         chirp_active_in;
    logic         chirp_done_in;
    logic         chirp_init_out;
    logic         chirp_enable_out;
    logic [31:0]  freq_offset_out;
    logic [31:0]  tuning_word_coeff_out;
    logic [31:0]  chirp_count_max_out;
    logic         busy_out;
    logic         burst_done_out;
    logic [15:0]  chirp_index_out;
    logic         timeout_err_out;
    logic [63:0]  chirp_timestamp_out;

    chirp_sequencer dut (
        .fmc_tclk              (fmc_tclk),
        .fmc_tresetn           (fmc_tresetn),
        .chirp_parameters_in   (chirp_parameters_in),
        .param_valid_in        (param_valid_in),
        .start_in              (start_in),
        .abort_in              (abort_in),
        .chirp_ready_in        (chirp_ready_in),
        .chirp_active_in       (chirp_active_in),
        .chirp_done_in         (chirp_done_in),
        .chirp_init_out        (chirp_init_out),
        .chirp_enable_out      (chirp_enable_out),
        .freq_offset_out       (freq_offset_out),
        .tuning_word_coeff_out (tuning_word_coeff_out),
        .chirp_count_max_out   (chirp_count_max_out),
        .busy_out              (busy_out),
        .burst_done_out        (burst_done_out),
        .chirp_index_out       (chirp_index_out),
        .timeout_err_out       (timeout_err_out),
        .chirp_timestamp_out   (chirp_timestamp_out)
    );

    always #5 fmc_tclk = ~fmc_tclk;

    int cyc = 0;
    always @(posedge fmc_tclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          m_on = 1'b0;
    int          m_c = 0;
    int          m_n = 1;
    int          m_gap = 0;
    logic [31:0] m_freq [0:7];
    logic [31:0] m_tw;
    logic [31:0] m_cm;
    int          m_inits[$];
    logic [31:0] m_freqs[$];
    int          m_bd = -1;
    logic [63:0] ts_prev = '0;
    int          init_total = 0;
    int          r, g, s, endd, e_idx, k;
    bit          e_init;

    function automatic int init_at(input int i);
        return (i < m_inits.size()) ? m_inits[i] : -1;
    endfunction

    function automatic logic [31:0] freq_at(input int i);
        return (i < m_freqs.size()) ? m_freqs[i] : 32'hFFFF_FFFF;
    endfunction

    // Per-cycle compare against the timeline model.
    always @(negedge fmc_tclk) begin
        if (chirp_init_out === 1'b1) init_total++;
        if (m_on) begin
            r     = cyc - m_c;
            g     = (m_gap < 2) ? 2 : m_gap;
            s     = 23 + g;
            endd  = 2 + (m_n - 1) * s + 22 + g;
            e_init = (r >= 2) && ((r - 2) % s == 0) && ((r - 2) / s < m_n);
            if (r < 24)                    e_idx = 0;
            else if ((r - 24) / s + 1 > m_n) e_idx = m_n;
            else                           e_idx = (r - 24) / s + 1;
            chk("init", 64'(chirp_init_out), 64'(e_init));
            chk("busy", 64'(busy_out), 64'(r >= 1 && r <= endd));
            chk("enable", 64'(chirp_enable_out), 64'(r >= 1 && r < endd));
            chk("burst_done", 64'(burst_done_out), 64'(r == endd));
            if (r >= 1) begin
                chk("index", 64'(chirp_index_out), 64'(e_idx));
                chk("timeout_err", 64'(timeout_err_out), 64'd0);
            end
            if (e_init) begin
                k = (r - 2) / s;
                chk("freq_offset", 64'(freq_offset_out), 64'(m_freq[k]));
                chk("tuning_word", 64'(tuning_word_coeff_out), 64'(m_tw));
                chk("count_max", 64'(chirp_count_max_out), 64'(m_cm));
            end
            if (chirp_init_out === 1'b1) begin
                m_inits.push_back(r);
                m_freqs.push_back(freq_offset_out);
            end
            if (burst_done_out === 1'b1) m_bd = r;
`ifdef CHIRP_SEQ_TIMESTAMP_EN
            if ((r >= 3) && ((r - 3) % s == 0) && ((r - 3) / s < m_n)) begin
                if ((r - 3) / s > 0) chk("ts_delta", chirp_timestamp_out - ts_prev, 64'(s));
                ts_prev = chirp_timestamp_out;
            end
`else
            chk("ts_zero", chirp_timestamp_out, 64'd0);
`endif
        end
    end

    // DDS stand-in: active from 1 cycle after init for 21 cycles, done on the last.
    int dds_t = 0;
    bit saw_init;
    initial begin
        chirp_active_in = 1'b0;
        chirp_done_in   = 1'b0;
        forever begin
            @(negedge fmc_tclk);
            saw_init = (chirp_init_out === 1'b1);
            @(posedge fmc_tclk);
            #1;
            if (saw_init)        dds_t = 1;
            else if (dds_t >= 21) dds_t = 0;
            else if (dds_t != 0) dds_t = dds_t + 1;
            chirp_active_in = (dds_t != 0);
            chirp_done_in   = (dds_t == 21);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] pw(input int gap, input int num, input int cm,
                                        input int tw, input int off);
        return {16'(gap), 16'(num), 32'(cm), 32'(tw), 32'(off)};
    endfunction

    task automatic load_shadow(input int gap, input int num, input int cm, input int tw, input int off);
        @(posedge fmc_tclk); #1;
        chirp_parameters_in = pw(gap, num, cm, tw, off);
        param_valid_in      = 1'b1;
        @(posedge fmc_tclk); #1;
        param_valid_in      = 1'b0;
    endtask

    // Pulses start_in for one cycle and returns one cycle later, in relative cycle 1.
    task automatic start_burst(input bit model);
        @(posedge fmc_tclk); #1;
        start_in = 1'b1;
        m_c      = cyc;
        if (model) begin
            m_inits.delete();
            m_freqs.delete();
            m_bd = -1;
            m_on = 1'b1;
        end
        @(posedge fmc_tclk); #1;
        start_in = 1'b0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - m_c < rel) begin
            @(posedge fmc_tclk); #1;
        end
    endtask

    task automatic set_model(input int n, input int gap, input int f0, input int f1, input int f2);
        m_n   = n;
        m_gap = gap;
        m_tw  = 32'd1;
        m_cm  = 32'd1023;
        for (int i = 0; i < 8; i++) m_freq[i] = 32'(f2);
        m_freq[0] = 32'(f0);
        m_freq[1] = 32'(f1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_init"}, 64'(chirp_init_out), 64'd0);
        chk({tag, "_enable"}, 64'(chirp_enable_out), 64'd0);
        chk({tag, "_freq"}, 64'(freq_offset_out), 64'd0);
        chk({tag, "_tw"}, 64'(tuning_word_coeff_out), 64'd0);
        chk({tag, "_cm"}, 64'(chirp_count_max_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
        chk({tag, "_bdone"}, 64'(burst_done_out), 64'd0);
        chk({tag, "_index"}, 64'(chirp_index_out), 64'd0);
        chk({tag, "_terr"}, 64'(timeout_err_out), 64'd0);
        chk({tag, "_ts"}, chirp_timestamp_out, 64'd0);
    endtask

    int init_before;
    int bd_seen;
    int busy_seen;

    initial begin
        fmc_tresetn         = 1'b0;
        chirp_parameters_in = '0;
        param_valid_in      = 1'b0;
        start_in            = 1'b0;
        abort_in            = 1'b0;
        chirp_ready_in      = 1'b0;
        repeat (3) @(posedge fmc_tclk);
        #1;
        check_all_zero("reset");
        fmc_tresetn = 1'b1;
        @(posedge fmc_tclk); #1;
        check_all_zero("post_reset");

        // Basic burst: 3 chirps, gap 10, init spacing 33.
        chirp_ready_in = 1'b1;
        load_shadow(10, 3, 1023, 1, 768);
        set_model(3, 10, 768, 768, 768);
        start_burst(1);
        wait_rel(102);
        m_on = 1'b0;
        chk("basic_n_inits", 64'(m_inits.size()), 64'd3);
        chk("basic_first_init", 64'(init_at(0)), 64'd2);
        chk("basic_spacing", 64'(init_at(1) - init_at(0)), 64'd33);
        chk("basic_spacing2", 64'(init_at(2) - init_at(1)), 64'd33);
        chk("basic_done_at", 64'(m_bd), 64'd100);
        chk("basic_index", 64'(chirp_index_out), 64'd3);

        // Gap clamp: programmed gap 0 behaves as 2.
        load_shadow(0, 2, 1023, 1, 768);
        set_model(2, 0, 768, 768, 768);
        start_burst(1);
        wait_rel(53);
        m_on = 1'b0;
        chk("clamp_spacing", 64'(init_at(1) - init_at(0)), 64'd25);
        chk("clamp_done_at", 64'(m_bd), 64'd51);

        // Mid-chirp parameter update takes effect on the next chirp.
        load_shadow(10, 3, 1023, 1, 768);
        set_model(3, 10, 768, 1536, 1536);
        start_burst(1);
        wait_rel(7);
        chirp_parameters_in = pw(10, 3, 1023, 1, 1536);
        param_valid_in      = 1'b1;
        @(posedge fmc_tclk); #1;
        param_valid_in      = 1'b0;
        wait_rel(102);
        m_on = 1'b0;
        chk("update_chirp1", 64'(freq_at(0)), 64'd768);
        chk("update_chirp2", 64'(freq_at(1)), 64'd1536);

        // Parameter word coincident with the INIT load bypasses the shadow.
        load_shadow(10, 1, 1023, 1, 1536);
        set_model(1, 10, 2048, 2048, 2048);
        start_burst(1);
        chirp_parameters_in = pw(10, 1, 1023, 1, 2048);
        param_valid_in      = 1'b1;
        @(posedge fmc_tclk); #1;
        param_valid_in      = 1'b0;
        wait_rel(36);
        m_on = 1'b0;
        chk("bypass_freq", 64'(freq_at(0)), 64'd2048);
        chk("bypass_done_at", 64'(m_bd), 64'd34);

        // Continuous mode, abort during the fifth chirp.
        load_shadow(10, 0, 1023, 1, 768);
        set_model(5, 10, 768, 768, 768);
        start_burst(1);
        wait_rel(139);
        abort_in = 1'b1;
        wait_rel(167);
        abort_in = 1'b0;
        wait_rel(168);
        m_on = 1'b0;
        chk("abort_n_inits", 64'(m_inits.size()), 64'd5);
        chk("abort_index", 64'(chirp_index_out), 64'd5);
        chk("abort_done_at", 64'(m_bd), 64'd166);

        // Timeout: ready held low.
        chirp_ready_in = 1'b0;
        init_before    = init_total;
        start_burst(0);
        wait_rel(4096);
        chk("tmo_arm_err", 64'(timeout_err_out), 64'd0);
        chk("tmo_arm_enable", 64'(chirp_enable_out), 64'd1);
        chk("tmo_arm_bdone", 64'(burst_done_out), 64'd0);
        wait_rel(4097);
        chk("tmo_done_bdone", 64'(burst_done_out), 64'd1);
        chk("tmo_done_err", 64'(timeout_err_out), 64'd1);
        chk("tmo_done_enable", 64'(chirp_enable_out), 64'd0);
        wait_rel(4098);
        chk("tmo_idle_busy", 64'(busy_out), 64'd0);
        chk("tmo_sticky", 64'(timeout_err_out), 64'd1);
        chk("tmo_no_init", 64'(init_total - init_before), 64'd0);

        // Next start clears the flag; abort in ARM ends the burst without an init.
        abort_in = 1'b1;
        start_burst(0);
        chk("clr_err", 64'(timeout_err_out), 64'd0);
        chk("arm_abort_enable", 64'(chirp_enable_out), 64'd1);
        wait_rel(2);
        chk("arm_abort_bdone", 64'(burst_done_out), 64'd1);
        wait_rel(3);
        chk("arm_abort_busy", 64'(busy_out), 64'd0);
        chk("arm_abort_no_init", 64'(init_total - init_before), 64'd0);
        abort_in = 1'b0;

        // Asynchronous reset while ACTIVE.
        chirp_ready_in = 1'b1;
        load_shadow(10, 3, 1023, 1, 768);
        start_burst(0);
        wait_rel(10);
        chk("pre_rst_busy", 64'(busy_out), 64'd1);
        chk("pre_rst_freq", 64'(freq_offset_out), 64'd768);
        #2;
        fmc_tresetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge fmc_tclk); #1;
        fmc_tresetn = 1'b1;
        bd_seen   = 0;
        busy_seen = 0;
        repeat (40) begin
            @(posedge fmc_tclk); #1;
            if (burst_done_out !== 1'b0) bd_seen++;
            if (busy_out !== 1'b0)       busy_seen++;
        end
        chk("rst_no_bdone", 64'(bd_seen), 64'd0);
        chk("rst_stays_idle", 64'(busy_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
